filter_output_arbiter: RTL and testbench

- Shares one force-pipeline input port among NUM_FILTERS filter_logic instances in a force evaluation unit.
- Round-robin grants filters that request output, pulses the granted filter's buffer read enable, and captures the returned home particle ID.
- Forwards the ID with its filter index through a 2-entry output queue under downstream back-pressure.
- Detects per-filter release (a read of an empty buffer) and reports when every filter has released the current neighbor.

---
 rtl/MD_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/filter_output_arbiter.sv | 148 ++++++++++++++
 tb/tb_filter_output_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
// Shared constants and types for the force evaluation unit filter output path.
package MD_pkg;
  localparam int NUM_FILTERS       = 8;
  localparam int PARTICLE_ID_WIDTH = 9;
  localparam int FILTER_ID_WIDTH   = $clog2(NUM_FILTERS);

  // One output queue entry: source filter index plus the home particle ID it returned
  typedef struct packed {
    logic [FILTER_ID_WIDTH-1:0]   filter_id;
    logic [PARTICLE_ID_WIDTH-1:0] home_parid;
  } arb_entry_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at index >= ptr, wrapping.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 grant_valid
);
  localparam int PW = $clog2(N);

  logic [N-1:0]  eligible;
  logic [PW-1:0] idx;
  int            sum;

  assign eligible = req & ~mask;

  // scan N positions starting at ptr; the first eligible one wins
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    sum         = 0;
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (!grant_valid && eligible[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/filter_output_arbiter.sv
// Shares the force-pipeline input port among NUM_FILTERS filters: round-robin
// read grants, a 2-entry output queue, and per-filter release tracking.
// FILTER_ARB_STATS_EN: when defined, o_grant_count counts rd_en issues and
// simulation-only per-filter grant counters are built; otherwise it is tied to 0.
module filter_output_arbiter
  import MD_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_FILTERS-1:0]                 i_filter_request,
  input  logic [NUM_FILTERS*PARTICLE_ID_WIDTH-1:0] i_filter_rd_data,
  input  logic [NUM_FILTERS-1:0]                 i_filter_rd_data_valid,
  input  logic                                   i_ready,
  output logic [NUM_FILTERS-1:0]                 o_filter_rd_en,
  output logic                                   o_valid,
  output logic [PARTICLE_ID_WIDTH-1:0]           o_home_parid,
  output logic [FILTER_ID_WIDTH-1:0]             o_filter_id,
  output logic                                   o_round_done,
  output logic [31:0]                            o_grant_count
);
  // stage 0: rd_en cycle, stage 1: return cycle
  localparam int STAGES = 1;

  logic [FILTER_ID_WIDTH-1:0] ptr;
  logic [NUM_FILTERS-1:0]     grant, released, rel_bit;
  logic                       grant_valid, issue, pop, ret_valid, ret_release;
  logic [STAGES:0]            vld_pipe;
  logic [FILTER_ID_WIDTH-1:0] idx_pipe [STAGES+1];
  logic [FILTER_ID_WIDTH-1:0] grant_idx, ret_idx;
  logic [1:0]                 occ;
  logic [2:0]                 load;
  arb_entry_t                 q [2];
  arb_entry_t                 ret_entry;
  logic                       rd_p, wr_p;

  // last cycle's grantee is masked: its request has not yet seen the read
  rr_arbiter #(.N(NUM_FILTERS)) u_rr (
    .req         (i_filter_request),
    .mask        (o_filter_rd_en),
    .ptr         (ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // one-hot grant to index
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_FILTERS; i++)
      if (grant[i]) grant_idx = FILTER_ID_WIDTH'(i);
  end

  // Reads in either pipeline stage will still land in the queue, so they hold
  // a slot; a pop this cycle frees one. This keeps the queue from ever
  // overflowing while still letting a pop and an issue share a cycle.
  assign pop   = o_valid & i_ready;
  assign load  = {1'b0, occ} + {2'b0, vld_pipe[0]} + {2'b0, vld_pipe[1]};
  assign issue = grant_valid && (load < (pop ? 3'd3 : 3'd2));

  // registered read enable, round-robin pointer and return pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      o_filter_rd_en <= '0;
      ptr            <= '0;
      vld_pipe       <= '0;
      for (int s = 0; s <= STAGES; s++) idx_pipe[s] <= '0;
    end else begin
      o_filter_rd_en <= issue ? grant : '0;
      vld_pipe       <= {vld_pipe[STAGES-1:0], issue};
      idx_pipe[0]    <= grant_idx;
      for (int s = 1; s <= STAGES; s++) idx_pipe[s] <= idx_pipe[s-1];
      if (issue)
        ptr <= (grant_idx == FILTER_ID_WIDTH'(NUM_FILTERS-1)) ? '0
                                                             : grant_idx + FILTER_ID_WIDTH'(1);
    end
  end

  // only the granted filter's valid/data are looked at in the return cycle
  assign ret_idx     = idx_pipe[STAGES];
  assign ret_valid   = vld_pipe[STAGES] &  i_filter_rd_data_valid[ret_idx];
  assign ret_release = vld_pipe[STAGES] & ~i_filter_rd_data_valid[ret_idx];
  assign ret_entry   = {ret_idx, i_filter_rd_data[ret_idx*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH]};

  assign o_valid      = (occ != 2'd0);
  assign o_home_parid = q[rd_p].home_parid;
  assign o_filter_id  = q[rd_p].filter_id;

  // 2-entry output FIFO; a push and a pop in the same cycle are both honored
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= '0;
      rd_p <= 1'b0;
      wr_p <= 1'b0;
      q[0] <= '0;
      q[1] <= '0;
    end else begin
      if (ret_valid) begin
        q[wr_p] <= ret_entry;
        wr_p    <= ~wr_p;
      end
      if (pop) rd_p <= ~rd_p;
      occ <= occ + {1'b0, ret_valid} - {1'b0, pop};
    end
  end

  assign o_round_done = &released;
  assign rel_bit      = ret_release ? (NUM_FILTERS'(1) << ret_idx) : '0;

  // release set: cleared on the done pulse, a release in that same cycle survives the clear
  always_ff @(posedge clk) begin
    if (rst) released <= '0;
    else     released <= (o_round_done ? '0 : released) | rel_bit;
  end

`ifdef FILTER_ARB_STATS_EN
  logic [31:0] grant_count;

  // total issued reads, wraps at 2^32
  always_ff @(posedge clk) begin
    if (rst)        grant_count <= '0;
    else if (issue) grant_count <= grant_count + 32'd1;
  end
  assign o_grant_count = grant_count;

`ifndef SYNTHESIS
  int unsigned filter_grants [NUM_FILTERS];

  // per-filter issue counts for debug visibility
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_FILTERS; i++) filter_grants[i] <= 0;
    else if (issue) filter_grants[grant_idx] <= filter_grants[grant_idx] + 1;
  end
`endif
`else
  assign o_grant_count = '0;
`endif

`ifndef SYNTHESIS
  // a filter answering with no read in the return stage, or a push into a full queue
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (vld_pipe[STAGES] || i_filter_rd_data_valid == '0)
        else $error("filter_output_arbiter: rd_data_valid with no read in flight");
      assert (!(ret_valid && occ == 2'd2 && !pop))
        else $error("filter_output_arbiter: output queue overflow");
    end
  end
`endif
endmodule

// File: tb/tb_filter_output_arbiter.sv
// Randomized self-checking bench: behavioural filter buffers, a scoreboard of
// returned IDs, and a spec-level round-robin / release model.
module tb_filter_output_arbiter;
  import MD_pkg::*;
  localparam int NF = NUM_FILTERS;
  localparam int PW = PARTICLE_ID_WIDTH;
  localparam int FW = FILTER_ID_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NF-1:0]        i_filter_request;
  logic [NF*PW-1:0]     i_filter_rd_data;
  logic [NF-1:0]        i_filter_rd_data_valid;
  logic                 i_ready;
  logic [NF-1:0]        o_filter_rd_en;
  logic                 o_valid;
  logic [PW-1:0]        o_home_parid;
  logic [FW-1:0]        o_filter_id;
  logic                 o_round_done;
  logic [31:0]          o_grant_count;

  filter_output_arbiter dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_filter_request       (i_filter_request),
    .i_filter_rd_data       (i_filter_rd_data),
    .i_filter_rd_data_valid (i_filter_rd_data_valid),
    .i_ready                (i_ready),
    .o_filter_rd_en         (o_filter_rd_en),
    .o_valid                (o_valid),
    .o_home_parid           (o_home_parid),
    .o_filter_id            (o_filter_id),
    .o_round_done           (o_round_done),
    .o_grant_count          (o_grant_count)
  );

  always #5 clk = ~clk;

  typedef struct { int fid; int pid; int c; } sb_t;

  int      n_cmp = 0, n_err = 0, cyc = 0;
  int      fq [NF][$];
  bit      rel_pend [NF];
  sb_t     sb [$];
  int      gseq [$];
  int      pend_rd = -1, m_ptr = 0;
  logic [NF-1:0] m_rel = '0, req_prev = '0, rd_prev = '0;
  int      rdy_mode = 1;
  bit      noise = 0;
  int      n_issue = 0, n_out = 0, n_done = 0;
  int      first_out = -1, last_rel_cyc = -1, done_cyc = -1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int work();
    int w;
    w = sb.size() + ((pend_rd >= 0) ? 1 : 0);
    for (int k = 0; k < NF; k++) w += fq[k].size() + (rel_pend[k] ? 1 : 0);
    return w;
  endfunction

  function automatic logic [63:0] exp_count();
`ifdef FILTER_ARB_STATS_EN
    return 64'(n_issue);
`else
    return 64'd0;
`endif
  endfunction

  // one clock: filters answer last read, check grant, round, output; drive requests
  task automatic step();
    logic [NF-1:0]    rd, vbits, req;
    logic [NF*PW-1:0] dbits;
    int  k, g, cand, id, j;
    bit  rel_now, exp_v;
    sb_t e;
    @(posedge clk); #1; cyc++;

    vbits = '0; rel_now = 0; k = 0;
    for (int i = 0; i < NF; i++) dbits[i*PW +: PW] = PW'($urandom);
    if (pend_rd >= 0) begin
      k = pend_rd;
      if (noise) vbits = NF'($urandom);
      if (fq[k].size() > 0) begin
        id = fq[k].pop_front();
        vbits[k] = 1'b1;
        dbits[k*PW +: PW] = PW'(id);
        sb.push_back('{k, id, cyc});
      end else begin
        vbits[k] = 1'b0;
        rel_pend[k] = 0;
        rel_now = 1;
      end
    end
    i_filter_rd_data_valid = vbits;
    i_filter_rd_data       = dbits;

    chk("round_done", 64'(o_round_done), 64'(m_rel == '1));
    if (o_round_done) begin n_done++; done_cyc = cyc; end
    if (m_rel == '1) m_rel = '0;
    if (rel_now) begin m_rel[k] = 1'b1; last_rel_cyc = cyc; end

    rd = o_filter_rd_en;
    pend_rd = -1;
    if (rd != '0) begin
      chk("rd_en_onehot", 64'($onehot(rd)), 64'd1);
      g = 0;
      for (int i = NF-1; i >= 0; i--) if (rd[i]) g = i;
      cand = -1;
      for (int i = 0; i < NF; i++) begin
        j = (m_ptr + i) % NF;
        if (cand < 0 && req_prev[j] && !rd_prev[j]) cand = j;
      end
      chk("rr_grant", 64'(g), 64'(cand));
      chk("no_back_to_back", 64'(rd_prev[g]), 64'd0);
      m_ptr = (g + 1) % NF;
      pend_rd = g;
      n_issue++;
      gseq.push_back(g);
    end

    case (rdy_mode)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
    exp_v = (sb.size() > 0) && (sb[0].c < cyc);
    chk("o_valid", 64'(o_valid), 64'(exp_v));
    if (o_valid && exp_v) begin
      if (first_out < 0) first_out = cyc;
      if (i_ready) begin
        e = sb.pop_front();
        chk("out_entry", 64'({o_filter_id, o_home_parid}), 64'({FW'(e.fid), PW'(e.pid)}));
        n_out++;
      end
    end

    for (int i = 0; i < NF; i++) req[i] = (fq[i].size() > 0) || rel_pend[i];
    i_filter_request = req;
    req_prev = req;
    rd_prev  = rd;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && work() != 0; i++) step();
    chk("drain_timeout", 64'(work()), 64'd0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < NF; k++) begin fq[k].delete(); rel_pend[k] = 0; end
    sb.delete(); gseq.delete();
    pend_rd = -1; m_ptr = 0; m_rel = '0; req_prev = '0; rd_prev = '0;
    n_issue = 0; n_out = 0; n_done = 0;
    first_out = -1; last_rel_cyc = -1; done_cyc = -1;
    i_filter_request = '0;
  endtask

  // synchronous reset over two edges; filters reset along with the arbiter
  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    i_filter_rd_data_valid = '0;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, k;
    rst = 1'b1; i_ready = 1'b1; i_filter_request = '0;
    i_filter_rd_data = '0; i_filter_rd_data_valid = '0;
    do_reset();

    // reset state
    chk("rst_rd_en",    64'(o_filter_rd_en), 64'd0);
    chk("rst_valid",    64'(o_valid),        64'd0);
    chk("rst_parid",    64'(o_home_parid),   64'd0);
    chk("rst_fid",      64'(o_filter_id),    64'd0);
    chk("rst_done",     64'(o_round_done),   64'd0);
    chk("rst_gcount",   64'(o_grant_count),  64'd0);

    // single filter 2: IDs 5,6,7 then a release read
    rdy_mode = 1;
    fq[2] = '{5, 6, 7}; rel_pend[2] = 1;
    step(); c0 = cyc;
    drain(60);
    repeat (3) step();
    chk("latency", 64'(first_out - c0), 64'd3);
    chk("single_outputs", 64'(n_out), 64'd3);
    chk("single_reads", 64'(gseq.size()), 64'd4);
    chk("single_no_round", 64'(n_done), 64'd0);

    // filters 0 and 3 compete: strict alternation
    do_reset();
    fq[0] = '{10, 11, 12, 13}; fq[3] = '{30, 31, 32, 33};
    drain(100);
    chk("alt_grants", 64'(gseq.size()), 64'd8);
    for (int i = 0; i < 8 && i < gseq.size(); i++)
      chk("alt_order", 64'(gseq[i]), 64'((i % 2) ? 3 : 0));
    chk("alt_gcount", 64'(o_grant_count), exp_count());

    // back-pressure: 4 pending IDs, i_ready low
    do_reset();
    rdy_mode = 0;
    fq[1] = '{100, 101}; fq[5] = '{500, 501};
    repeat (12) step();
    chk("bp_queued", 64'(sb.size()), 64'd2);
    chk("bp_rd_en_low", 64'(o_filter_rd_en), 64'd0);
    chk("bp_valid", 64'(o_valid), 64'd1);
    rdy_mode = 1; n_out = 0;
    drain(100);
    chk("bp_drained", 64'(n_out), 64'd4);

    // all filters release once: one round_done pulse, one cycle after the last release
    do_reset();
    for (int i = 0; i < NF; i++) rel_pend[i] = 1;
    drain(100);
    repeat (3) step();
    chk("round_pulses", 64'(n_done), 64'd1);
    chk("round_timing", 64'(done_cyc - last_rel_cyc), 64'd1);
    chk("round_cleared", 64'(o_round_done), 64'd0);

    // reset with a read in flight and an entry queued
    do_reset();
    rdy_mode = 0;
    fq[4] = '{40, 41, 42};
    for (int i = 0; i < 30 && !(o_valid && o_filter_rd_en != '0); i++) step();
    chk("mid_setup_rd", 64'(o_filter_rd_en != '0), 64'd1);
    chk("mid_setup_valid", 64'(o_valid), 64'd1);
    rst = 1'b1;
    clear_model();
    @(posedge clk); #1; cyc++;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_rd_en", 64'(o_filter_rd_en), 64'd0);
    i_filter_rd_data_valid = '1;
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    i_filter_rd_data_valid = '0;
    rdy_mode = 1;
    repeat (5) step();
    fq[6] = '{66}; fq[1] = '{11};
    step(); step();
    chk("ptr_after_rst", 64'((gseq.size() > 0) ? gseq[0] : -1), 64'd1);
    drain(60);

    // random traffic with back-pressure and stray valids from idle filters
    do_reset();
    rdy_mode = 2; noise = 1;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NF-1);
        if (fq[k].size() < 4) fq[k].push_back($urandom_range(0, (1 << PW) - 1));
      end
      if ($urandom_range(0, 31) == 0) rel_pend[$urandom_range(0, NF-1)] = 1;
      step();
    end
    rdy_mode = 1;
    drain(400);
    repeat (3) step();
    chk("rand_gcount", 64'(o_grant_count), exp_count());
    chk("rand_all_out", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
